// File: rtl/audio_pkg.sv
// audio_pkg: shared audio sample/frame geometry and I2S word-select slot encodings
package audio_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 64;
    typedef enum logic {WS_LEFT = 1'b0, WS_RIGHT = 1'b1} ws_slot_e;
endpackage

// File: rtl/i2s_bck_gen.sv
// i2s_bck_gen: bit-clock prescaler producing bck and a one-cycle falling-edge enable
module i2s_bck_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic bck,
    output logic fall_en
);
    logic [7:0] cnt;
    logic       tick;
    // tick marks the last prescaler count; a tick while bck is high is the falling edge
    always_comb begin
        tick    = cnt == 8'(BCLK_DIV - 1);
        fall_en = tick && bck;
    end
    // prescaler wraps on tick, and bck toggles on that same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            bck <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 8'd1;
            bck <= bck ^ tick;
        end
    end
endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: Philips I2S serialiser for a 16-bit stereo pair in a 64-bit frame
module i2s_transmitter
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] left,
    input  logic [SAMPLE_W-1:0] right,
    output logic                i2s_bck,
    output logic                i2s_ws,
    output logic                i2s_data,
    output logic                sample_strobe
);
    localparam int BW = $clog2(FRAME_BITS);
    localparam int PW = BW - 1;
    localparam int SW = $clog2(SAMPLE_W);
    logic                fall_en;
    logic [BW-1:0]       bit_cnt;
    logic [BW-1:0]       nxt_cnt;
    logic [PW-1:0]       pos;
    logic [SW-1:0]       idx;
    logic                nxt_data;
    logic                wrap;
    logic [SAMPLE_W-1:0] left_sh;
    logic [SAMPLE_W-1:0] right_sh;

    i2s_bck_gen #(.BCLK_DIV(BCLK_DIV)) u_bck (
        .clk     (clk),
        .reset_n (reset_n),
        .bck     (i2s_bck),
        .fall_en (fall_en)
    );

    // the bit being entered is bit_cnt+1, so with the one-bit delay its sample index follows bit_cnt's slot position
    always_comb begin
        nxt_cnt  = bit_cnt + BW'(1);
        wrap     = bit_cnt == '1;
        pos      = bit_cnt[PW-1:0];
        idx      = SW'(SAMPLE_W - 1) - pos[SW-1:0];
        nxt_data = pos < PW'(SAMPLE_W) ? (bit_cnt[BW-1] ? right_sh[idx] : left_sh[idx]) : 1'b0;
    end
    // frame state advances on bck falling edges; inputs are latched only at the frame wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt       <= '1;
            i2s_ws        <= WS_RIGHT;
            i2s_data      <= 1'b0;
            sample_strobe <= 1'b0;
            left_sh       <= '0;
            right_sh      <= '0;
        end else begin
            sample_strobe <= fall_en && wrap;
            if (fall_en) begin
                bit_cnt  <= nxt_cnt;
                i2s_ws   <= nxt_cnt[BW-1] ? WS_RIGHT : WS_LEFT;
                i2s_data <= nxt_data;
                if (wrap) begin
                    left_sh  <= left;
                    right_sh <= right;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: directed checks of reset, serialisation, capture isolation, mid-frame reset and timing
module tb_i2s_transmitter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] left = 16'h0;
    logic [15:0] right = 16'h0;
    logic        a_bck, a_ws, a_data, a_strobe;
    logic        b_bck, b_ws, b_data, b_strobe;
    int          n_chk = 0;
    int          n_fail = 0;
    int          ka, kb, p;
    logic [63:0] dv, wv;

    always #5 clk = ~clk;

    i2s_transmitter #(.BCLK_DIV(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .left(left), .right(right),
        .i2s_bck(a_bck), .i2s_ws(a_ws), .i2s_data(a_data), .sample_strobe(a_strobe)
    );
    i2s_transmitter #(.BCLK_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .left(left), .right(right),
        .i2s_bck(b_bck), .i2s_ws(b_ws), .i2s_data(b_data), .sample_strobe(b_strobe)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bit 0 of the frame is the MSB of this vector
    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
    endfunction

    function automatic logic sig(input int s);
        case (s)
            0: return a_bck;
            1: return a_strobe;
            2: return b_bck;
            default: return b_strobe;
        endcase
    endfunction

    task automatic period(input int s, output int per);
        int   t0;
        logic prev;
        t0   = -1;
        per  = -1;
        prev = sig(s);
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            if (sig(s) && !prev) begin
                if (t0 < 0) t0 = i;
                else begin
                    per = i - t0;
                    break;
                end
            end
            prev = sig(s);
        end
    endtask

    task automatic wait_a_strobe(output int k);
        k = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            if (a_strobe) begin
                k = i;
                break;
            end
        end
    endtask

    // starts at the strobe cycle (bit 0) and ends at the next frame's strobe cycle
    task automatic read_frame(input int cb, input logic [15:0] cv, output logic [63:0] d, output logic [63:0] w);
        for (int b = 0; b < 64; b++) begin
            d[63-b] = a_data;
            w[63-b] = a_ws;
            if (b == cb) left = cv;
            if (b == 0) begin
                @(posedge clk); #1;
                chk("strobe_width", {63'b0, a_strobe}, 64'd0);
                repeat (7) @(posedge clk);
            end else begin
                repeat (8) @(posedge clk);
            end
            #1;
        end
        chk("frame_strobe", {63'b0, a_strobe}, 64'd1);
    endtask

    initial begin
        left  = 16'h8001;
        right = 16'h00F0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_bck", {63'b0, a_bck}, 64'd0);
        chk("rst_ws", {63'b0, a_ws}, 64'd1);
        chk("rst_data", {63'b0, a_data}, 64'd0);
        chk("rst_strobe", {63'b0, a_strobe}, 64'd0);
        chk("rst_b_bck", {63'b0, b_bck}, 64'd0);
        chk("rst_b_ws", {63'b0, b_ws}, 64'd1);
        chk("rst_b_data", {63'b0, b_data}, 64'd0);
        reset_n = 1'b1;
        ka = 0;
        kb = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (b_strobe && kb == 0) kb = i;
            if (a_strobe) begin
                ka = i;
                break;
            end
        end
        chk("first_strobe_div4", 64'(ka), 64'd8);
        chk("first_strobe_div1", 64'(kb), 64'd2);

        read_frame(-1, 16'h0, dv, wv);
        chk("frame1_data", dv, exp_frame(16'h8001, 16'h00F0));
        chk("frame1_ws", wv, {32'h0, 32'hFFFF_FFFF});
        chk("ws_bit0", {63'b0, wv[63]}, 64'd0);
        chk("ws_bit31", {63'b0, wv[32]}, 64'd0);
        chk("ws_bit32", {63'b0, wv[31]}, 64'd1);

        read_frame(20, 16'h1234, dv, wv);
        chk("frame2_data", dv, exp_frame(16'h8001, 16'h00F0));
        right = 16'h0180;
        read_frame(8, 16'hFFFF, dv, wv);
        chk("frame3_data", dv, exp_frame(16'h1234, 16'h00F0));
        read_frame(-1, 16'h0, dv, wv);
        chk("frame4_data", dv, exp_frame(16'hFFFF, 16'h0180));

        repeat (324) @(posedge clk);
        #1;
        chk("bit40_bck", {63'b0, a_bck}, 64'd1);
        chk("bit40_ws", {63'b0, a_ws}, 64'd1);
        chk("bit40_data", {63'b0, a_data}, 64'd1);
        left    = 16'hABCD;
        right   = 16'h5A5A;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bck", {63'b0, a_bck}, 64'd0);
        chk("mid_rst_ws", {63'b0, a_ws}, 64'd1);
        chk("mid_rst_data", {63'b0, a_data}, 64'd0);
        chk("mid_rst_strobe", {63'b0, a_strobe}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_a_strobe(ka);
        chk("restart_strobe", 64'(ka), 64'd8);
        read_frame(-1, 16'hABCD, dv, wv);
        chk("restart_data", dv, exp_frame(16'hABCD, 16'h5A5A));
        chk("restart_ws", wv, {32'h0, 32'hFFFF_FFFF});

        period(0, p);
        chk("bck_period_div4", 64'(p), 64'd8);
        period(1, p);
        chk("strobe_period_div4", 64'(p), 64'd512);
        period(2, p);
        chk("bck_period_div1", 64'(p), 64'd2);
        period(3, p);
        chk("strobe_period_div1", 64'(p), 64'd128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
